// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types and helpers for the bit-serial comparator
//
// Purpose : FSM state encoding, one-hot result encoding and cascade-input
//           normalisation shared by serial_lsb_comparator and serial_cmp_step.
// Ports   : none (package).

package serial_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Result is carried as a one-hot {less, equal, greater} vector.
    localparam int          RES_W       = 3;
    localparam logic [2:0]  RES_LESS    = 3'b100;
    localparam logic [2:0]  RES_EQUAL   = 3'b010;
    localparam logic [2:0]  RES_GREATER = 3'b001;

    // Collapse arbitrary cascade inputs to a one-hot result.
    // Priority gin > lin > ein; an all-zero cascade means "no lower-order
    // context", which is the same as equal.
    function automatic logic [2:0] normalise_cascade(
        input logic lin,
        input logic ein,
        input logic gin
    );
        logic [2:0] res;
        res = RES_EQUAL;
        casez ({gin, lin, ein})
            3'b1??:  res = RES_GREATER;
            3'b01?:  res = RES_LESS;
            3'b001:  res = RES_EQUAL;
            default: res = RES_EQUAL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/serial_cmp_step.sv
// rtl/serial_cmp_step.sv - one-bit LSB-first comparison step
//
// Purpose : Given one bit of each operand and the result accumulated from all
//           lower-order bits, produce the result including this bit. A
//           differing bit at a higher position overrides whatever the lower
//           bits decided; equal bits pass the lower-order result through.
// Ports   :
//   xb_i   bit of operand X at the current position
//   yb_i   bit of operand Y at the current position
//   res_i  one-hot {less, equal, greater} from lower-order bits
//   res_o  one-hot {less, equal, greater} including this bit

module serial_cmp_step
    import serial_cmp_pkg::*;
(
    input  logic             xb_i,
    input  logic             yb_i,
    input  logic [RES_W-1:0] res_i,
    output logic [RES_W-1:0] res_o
);

    always_comb begin
        res_o = res_i;
        if (xb_i && !yb_i) begin
            res_o = RES_GREATER;
        end else if (!xb_i && yb_i) begin
            res_o = RES_LESS;
        end
    end

endmodule

// File: rtl/serial_lsb_comparator.sv
// rtl/serial_lsb_comparator.sv - bit-serial LSB-first magnitude comparator
//
// Purpose : Compares two N-bit unsigned words one bit per cycle, starting at
//           the LSB, seeded by cascade inputs from lower-order words. The
//           result needs N cycles after acceptance and is held until the
//           consumer takes it.
// Ports   :
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake (in_ready high only in IDLE)
//   x, y               operands, sampled only at acceptance
//   lin, ein, gin      cascade context from lower-order words
//   out_valid/out_ready result handshake
//   less/equal/greater registered one-hot result
//   busy               high while bits are being processed

module serial_lsb_comparator
    import serial_cmp_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         lin,
    input  logic         ein,
    input  logic         gin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         less,
    output logic         equal,
    output logic         greater,
    output logic         busy
);

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e             state_q,     state_d;
    logic [CW-1:0]      cnt_q,       cnt_d;
    logic [N-1:0]       xs_q,        xs_d;
    logic [N-1:0]       ys_q,        ys_d;
    logic [RES_W-1:0]   res_q,       res_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;

    logic [RES_W-1:0]   step_res;

    // Bit 0 of the shift registers always holds bit[cnt_q] of the operands.
    serial_cmp_step u_step (
        .xb_i  (xs_q[0]),
        .yb_i  (ys_q[0]),
        .res_i (res_q),
        .res_o (step_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        res_d   = res_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    xs_d    = x;
                    ys_d    = y;
                    res_d   = normalise_cascade(lin, ein, gin);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d = step_res;
                xs_d  = {1'b0, xs_q[N-1:1]};
                ys_d  = {1'b0, ys_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake/status outputs are decoded from the next state so they
        // can be registered alongside it and change on the same edge.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            xs_q        <= '0;
            ys_q        <= '0;
            res_q       <= RES_EQUAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign less      = res_q[2];
    assign equal     = res_q[1];
    assign greater   = res_q[0];

endmodule

// File: doc/serial_lsb_comparator.md
Name: serial_lsb_comparator

Overview:
- Sequential, bit-serial magnitude comparator: compares two N-bit unsigned words one bit per cycle, LSB first.
- Complements the combinational MSB-first cascaded comparator: same less/equal/greater cascade semantics, opposite processing direction, trading area for N cycles of latency.
- Sits behind a valid/ready producer and feeds a valid/ready consumer.
- Cascade inputs allow chaining words: lower-order words are compared first.

Parameters:
- N, 8, operand width in bits (N >= 2).
- CW, $clog2(N), bit-counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and cascade inputs valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- x  input  N  operand X, unsigned.
- y  input  N  operand Y, unsigned.
- lin  input  1  cascade: less-significant context says X<Y.
- ein  input  1  cascade: less-significant context says X==Y.
- gin  input  1  cascade: less-significant context says X>Y.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- less  output  1  X<Y, including cascade context.
- equal  output  1  X==Y, including cascade context.
- greater  output  1  X>Y, including cascade context.
- busy  output  1  high in RUN.

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE, counter = 0, shift registers = 0.
  - in_ready = 1, out_valid = 0, busy = 0.
  - less = 0, equal = 1, greater = 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid && in_ready at edge E0: load x and y into shift registers, load the result register from the normalised cascade inputs, set counter = 0, go to RUN.
- Cascade normalisation: priority gin > lin > ein. All-zero cascade inputs are treated as equal. The result register is always one-hot.
- RUN (busy = 1, in_ready = 0). Each edge processes bit 0 of the shift registers (which holds bit[counter] of the original operands):
  - xb=1, yb=0 → result = greater.
  - xb=0, yb=1 → result = less.
  - xb == yb → result unchanged.
  - Then shift both registers right by 1 and increment counter.
  - At the edge where counter == N-1 is processed, go to DONE.
- Latency: bits are processed at edges E1..EN. out_valid = 1 immediately after edge EN, i.e. N cycles after acceptance.
- Higher bits override lower bits by construction, so the final result equals the MSB-first cascade result.
- DONE:
  - out_valid = 1; less/equal/greater are stable and exactly one-hot.
  - Hold until out_valid && out_ready, then go to IDLE with out_valid = 0 on that edge.
  - in_ready stays 0 in DONE. No overlap: a new operand is accepted at the earliest one cycle after the handshake.
- Outputs less/equal/greater are registered. They reflect the result register in all states but are meaningful only when out_valid = 1. They keep the last result in IDLE.
- Input stability:
  - in_valid without in_ready is ignored; no state change.
  - x, y, lin, ein, gin are sampled only at acceptance; later changes have no effect.
- out_ready while out_valid = 0 is ignored.
- Reset mid-operation (RUN or DONE): return immediately to reset values; the pending result is discarded and no out_valid pulse is produced.
- Boundary values:
  - x = y = 0 with ein → equal.
  - x = 2^N-1, y = 0 → greater regardless of cascade.
- Throughput: one comparison per N+2 cycles minimum (accept, N run cycles, handshake).

Decomposition:
- Package serial_cmp_pkg:
  - State enum (IDLE, RUN, DONE).
  - Result encoding constants RES_LESS, RES_EQUAL, RES_GREATER (3-bit one-hot).
  - Cascade-normalisation function.
- Sub-module serial_cmp_step: combinational, inputs xb, yb, 3-bit current result; output 3-bit next result. It is the LSB-first counterpart of the one-bit cascade cell and is instantiated once in the datapath.

Test Plan:
- x=8'h5A, y=8'h5A, ein=1, out_ready=1 → out_valid 8 cycles after acceptance; equal=1, less=0, greater=0.
- x=8'h80, y=8'h7F, ein=1 → greater=1 (MSB overrides lower bits where y is larger).
- x=8'h01, y=8'h00, lin=1 → greater=1. Also x=y=8'h33, lin=1 → less=1 (cascade propagates through an equal word).
- Back-pressure: x=8'h10, y=8'h20, out_ready=0 for 5 cycles → out_valid and less=1 held stable, in_ready=0 throughout; after out_ready=1, in_ready=1 on the next cycle.
- Reset: assert rst_n=0 at bit 4 of RUN → outputs return to reset values immediately; the next operands (x=8'hFF, y=8'h00) produce greater=1 with normal latency.
- Non-one-hot cascade: gin=lin=1, x=y → greater=1. All-zero cascade, x=y → equal=1. Held in_valid during RUN is not re-accepted.
